keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Parametrised matrix-keypad scanner: drives one-hot rows, samples asynchronous columns,
//   debounces press and release, and emits one key code per press as a 1-cycle strobe.
//   Keeps a two-entry key history (last/prev) that feeds the two-digit 7-seg display mux.
//   Sits between the keypad pins and the display datapath, all on the system clk.
// PARAMETERS
//   NROWS        4       number of row drive lines
//   NCOLS        4       number of column sense lines
//   SCAN_DIV     1000    clk cycles each row is driven (dwell)
//   DEBOUNCE_CYC 20000   clk cycles a level must be stable to count as a press/release
//   REPEAT_CYC   500000  auto-repeat interval; used only when KEYPAD_REPEAT_EN is defined
//   localparam CODE_W = $clog2(NROWS*NCOLS)
// PORTS
//   clk       in   1       system clock
//   reset     in   1       asynchronous, active-low reset
//   col       in   NCOLS   raw column sense, active-high, asynchronous to clk
//   r_sel     out  NROWS   one-hot active-high row drive
//   key_code  out  CODE_W  code of the debounced key = row*NCOLS + col
//   key_valid out  1       1-cycle strobe; key_code is valid in that cycle
//   key_held  out  1       high while the accepted key is held or being release-debounced
//   last_key  out  CODE_W  most recent accepted code
//   prev_key  out  CODE_W  code accepted before last_key
// BEHAVIOUR
//   - Reset (reset=0, async): state=S_SCAN, r_sel=1 (row 0), all counters=0, key_code=0,
//     key_valid=0, key_held=0, last_key=0, prev_key=0. Mid-operation reset aborts at once;
//     no pending strobe is emitted.
//   - col passes a 2-FF synchroniser; all decisions use the synchronised value (2-cycle latency).
//   - S_SCAN: r_sel advances one row every SCAN_DIV cycles; row NROWS-1 wraps to row 0. On the
//     last dwell cycle, if sync col != 0: latch row and lowest-index set column, go to S_DEBOUNCE.
//     r_sel freezes.
//   - S_DEBOUNCE: count while the latched column bit stays 1. If it drops: clear the count, go
//     to S_SCAN and resume at the next row. When the count reaches DEBOUNCE_CYC: go to S_HELD.
//     In that same cycle key_valid=1, key_code=code, prev_key<=last_key, last_key<=code.
//   - S_HELD: key_held=1. Other columns and rows are ignored. When the latched bit goes to 0:
//     go to S_RELEASE with the count cleared.
//   - S_RELEASE: key_held=1. If the bit returns high: back to S_HELD with no new strobe.
//     After DEBOUNCE_CYC consecutive low cycles: go to S_SCAN at the next row; key_held=0.
//   - Multiple columns high in one row at detection: the lowest column index wins.
//   - Press-to-strobe latency is 2 + DEBOUNCE_CYC cycles after the row dwell sample.
//   - Counter widths: $clog2(max(SCAN_DIV, DEBOUNCE_CYC, REPEAT_CYC)+1); counters never wrap.
//   - key_code holds its value between strobes.
// CONFIGURATION
//   KEYPAD_REPEAT_EN defined: in S_HELD a repeat counter runs.
//     Every REPEAT_CYC cycles it emits another key_valid strobe with the same code, shifts the
//     history, and restarts. It resets on leaving S_HELD, and S_RELEASE->S_HELD also restarts it.
//   Not defined: exactly one strobe per press; REPEAT_CYC is ignored and no repeat logic is built.
// STRUCTURE
//   Package keypad_pkg:
//     typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} kp_state_t;
//     function lowest_set_idx().
//   Sub-module keypad_sync: parametrised-width 2-FF synchroniser with async active-low reset.
//     Instanced once on col.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_CYC=16, NROWS=NCOLS=4)
//   1. reset=0 -> r_sel=0001, key_valid=0, last_key=prev_key=0.
//      Release -> r_sel 0001->0010 after 4 clks; 1000 wraps to 0001.
//   2. col=0010 while r_sel=0100, held 40 clks -> exactly one key_valid with key_code=9,
//      last_key=9, key_held=1. Drop col -> key_held=0 8 clks after the synchronised drop.
//   3. col=0010 glitch for 3 clks on row 2 -> no key_valid; r_sel resumes at 1000.
//   4. Press code 5, release, press code 10 -> prev_key=5, last_key=10, two strobes total.
//   5. col=0110 on row 1 -> key_code=5. Press col 3 on another row while held -> ignored.
//   6. Reset asserted mid-S_DEBOUNCE -> outputs cleared at once, no strobe.
//      With KEYPAD_REPEAT_EN, hold 8+48 clks -> 4 strobes, all code 9.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type and helper functions for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} kp_state_t;
  function automatic int lowest_set_idx(input logic [31:0] v);
    lowest_set_idx = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) lowest_set_idx = i;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    max3 = (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus key-code outputs; master = scanner, slave = keypad/display side
interface keypad_scanner_if #(parameter int NROWS = 4, parameter int NCOLS = 4);
  localparam int CODE_W = $clog2(NROWS * NCOLS);
  logic [NCOLS-1:0]  col;
  logic [NROWS-1:0]  r_sel;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;
  logic [CODE_W-1:0] last_key;
  logic [CODE_W-1:0] prev_key;
  modport master(input col, output r_sel, key_code, key_valid, key_held, last_key, prev_key);
  modport slave(output col, input r_sel, key_code, key_valid, key_held, last_key, prev_key);
endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: W-bit 2-FF synchroniser (clk, reset async active-low, i_d raw in, o_q synced out)
module keypad_sync #(parameter int W = 4) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {o_q, r_meta} <= '0;
    else {o_q, r_meta} <= {r_meta, i_d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scan, debounce and one-strobe-per-press key coder; clk, reset (async active-low), bus (keypad_scanner_if.master); KEYPAD_REPEAT_EN adds auto-repeat while held
module keypad_scanner import keypad_pkg::*; #(
  parameter int NROWS        = 4,
  parameter int NCOLS        = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int REPEAT_CYC   = 500000
) (
  input logic clk,
  input logic reset,
  keypad_scanner_if.master bus
);
  localparam int CODE_W = $clog2(NROWS * NCOLS);
  localparam int CNT_W  = $clog2(max3(SCAN_DIV, DEBOUNCE_CYC, REPEAT_CYC) + 1);
  localparam int RW     = $clog2(NROWS);
  localparam int CIW    = $clog2(NCOLS);
  kp_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [RW-1:0]     r_row;
  logic [CIW-1:0]    r_cidx;
  logic [NROWS-1:0]  r_rowsel;
  logic [CODE_W-1:0] r_code, r_last, r_prev;
  logic              r_valid, r_held;
`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0]  r_rpt;
`endif
  logic [NCOLS-1:0]  w_col;
  logic [RW-1:0]     w_row_nx;
  logic [CODE_W-1:0] w_code;
  logic              w_bit, w_scan_end, w_deb_end;
  keypad_sync #(.W(NCOLS)) u_sync (.clk(clk), .reset(reset), .i_d(bus.col), .o_q(w_col));
  assign w_bit      = w_col[r_cidx];
  assign w_row_nx   = (r_row == RW'(NROWS - 1)) ? '0 : r_row + 1'b1;
  assign w_code     = CODE_W'(int'(r_row) * NCOLS + int'(r_cidx));
  assign w_scan_end = r_cnt == CNT_W'(SCAN_DIV - 1);
  assign w_deb_end  = r_cnt == CNT_W'(DEBOUNCE_CYC - 1);
  // r_row/r_rowsel only move on a row change, so they stay frozen from detection until release
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state  <= S_SCAN;
      r_cnt    <= '0;
      r_row    <= '0;
      r_cidx   <= '0;
      r_rowsel <= NROWS'(1);
      r_code   <= '0;
      r_last   <= '0;
      r_prev   <= '0;
      r_valid  <= 1'b0;
      r_held   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rpt    <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rpt   <= '0;
`endif
      case (r_state)
        S_SCAN:
          if (!w_scan_end) r_cnt <= r_cnt + 1'b1;
          else begin
            r_cnt <= '0;
            if (|w_col) begin
              r_state <= S_DEBOUNCE;
              r_cidx  <= CIW'(lowest_set_idx(32'(w_col)));
            end else begin
              r_row    <= w_row_nx;
              r_rowsel <= NROWS'(1) << w_row_nx;
            end
          end
        S_DEBOUNCE:
          if (!w_bit) begin
            r_cnt    <= '0;
            r_state  <= S_SCAN;
            r_row    <= w_row_nx;
            r_rowsel <= NROWS'(1) << w_row_nx;
          end else if (w_deb_end) begin
            r_cnt   <= '0;
            r_state <= S_HELD;
            r_held  <= 1'b1;
            r_valid <= 1'b1;
            r_code  <= w_code;
            r_prev  <= r_last;
            r_last  <= w_code;
          end else r_cnt <= r_cnt + 1'b1;
        S_HELD:
          if (!w_bit) begin
            r_state <= S_RELEASE;
            r_cnt   <= '0;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (r_rpt == CNT_W'(REPEAT_CYC - 1)) begin
            r_valid <= 1'b1;
            r_prev  <= r_last;
            r_last  <= r_code;
          end else r_rpt <= r_rpt + 1'b1;
`endif
        S_RELEASE:
          if (w_bit) begin
            r_state <= S_HELD;
            r_cnt   <= '0;
          end else if (w_deb_end) begin
            r_state  <= S_SCAN;
            r_cnt    <= '0;
            r_held   <= 1'b0;
            r_row    <= w_row_nx;
            r_rowsel <= NROWS'(1) << w_row_nx;
          end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= S_SCAN;
      endcase
    end
  assign bus.r_sel     = r_rowsel;
  assign bus.key_code  = r_code;
  assign bus.key_valid = r_valid;
  assign bus.key_held  = r_held;
  assign bus.last_key  = r_last;
  assign bus.prev_key  = r_prev;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: physical keypad model + scoreboard of expected key codes for keypad_scanner
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] glitch;
  logic [3:0] pm [4];
  int checks = 0, errors = 0, n_strobes = 0;
  int exp_q[$];
  int exp_last = 0, exp_prev = 0;
  always #5 clk = ~clk;
  keypad_scanner_if #(.NROWS(4), .NCOLS(4)) kif ();
  keypad_scanner #(.NROWS(4), .NCOLS(4), .SCAN_DIV(4), .DEBOUNCE_CYC(8), .REPEAT_CYC(16)) dut (
    .clk(clk), .reset(reset), .bus(kif.master));
  // a pressed key connects its row line to its column line, so only the driven row is visible
  always_comb begin
    kif.col = glitch;
    for (int r = 0; r < 4; r++) if (kif.r_sel[r]) kif.col = kif.col | pm[r];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int low_col(input int m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction
  always @(negedge clk)
    if (!reset) begin
      exp_last = 0;
      exp_prev = 0;
    end else if (kif.key_valid) begin
      int e;
      n_strobes++;
`ifdef KEYPAD_REPEAT_EN
      e = (exp_q.size() != 0) ? exp_q.pop_front() : exp_last;
`else
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got code %0d expected no strobe", kif.key_code);
        e = int'(kif.key_code);
      end else e = exp_q.pop_front();
`endif
      chk("key_code", kif.key_code, e);
      exp_prev = exp_last;
      exp_last = e;
      chk("last_key", kif.last_key, exp_last);
      chk("prev_key", kif.prev_key, exp_prev);
    end else chk("code_hold", kif.key_code, exp_last);
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_release();
    int n = 0;
    while (kif.key_held && n < 20) begin
      tick(1);
      n++;
    end
    chk("release_timeout", kif.key_held, 0);
  endtask
  task automatic press(input int r, input int m, input int hold, input int other, input bit bounce);
    pm[r] = m[3:0];
    exp_q.push_back(r * 4 + low_col(m));
    tick(hold);
    chk("key_held", kif.key_held, 1);
    if (other >= 0) begin
      pm[other] = 4'b1000;
      tick(12);
      chk("other_row_held", kif.key_held, 1);
    end
    if (bounce) begin
      pm[r] = 4'b0000;
      tick(3);
      pm[r] = m[3:0];
      tick(5);
    end
    pm[r] = 4'b0000;
    if (other >= 0) pm[other] = 4'b0000;
    tick(8);
    chk("release_debounce", kif.key_held, 1);
    wait_release();
  endtask
  task automatic wait_row(input logic [3:0] row);
    int n = 0;
    while (kif.r_sel != row && n < 40) begin
      tick(1);
      n++;
    end
    chk("wait_row", kif.r_sel, row);
  endtask
  initial begin
    glitch = '0;
    for (int r = 0; r < 4; r++) pm[r] = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_r_sel", kif.r_sel, 4'b0001);
    chk("rst_valid", kif.key_valid, 0);
    chk("rst_held", kif.key_held, 0);
    chk("rst_last", kif.last_key, 0);
    chk("rst_prev", kif.prev_key, 0);
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] one;
      one = 4'b0001;
      #0 chk("scan_r_sel", kif.r_sel, one << (k % 4));
      tick(4);
    end
    press(2, 4'b0010, 40, -1, 1'b0);
    chk("t2_last", kif.last_key, 9);
    tick(3);
    wait_row(4'b0100);
    glitch = 4'b0010;
    tick(3);
    glitch = 4'b0000;
    tick(4);
    chk("glitch_resume", kif.r_sel, 4'b1000);
    press(1, 4'b0010, 40, -1, 1'b0);
    press(2, 4'b0100, 40, -1, 1'b0);
    chk("t4_prev", kif.prev_key, 5);
    chk("t4_last", kif.last_key, 10);
    press(1, 4'b0110, 40, 3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      int r, m, o;
      r = $urandom_range(0, 3);
      m = $urandom_range(1, 15);
      o = ($urandom_range(0, 2) == 0) ? (r + 1 + $urandom_range(0, 2)) % 4 : -1;
      press(r, m, $urandom_range(30, 45), o, $urandom_range(0, 1) == 1);
      tick($urandom_range(0, 6));
    end
`ifdef KEYPAD_REPEAT_EN
    begin
      int n0, n = 0;
      tick(2);
      n0 = n_strobes;
      pm[2] = 4'b0010;
      exp_q.push_back(9);
      while (!kif.key_held && n < 40) begin
        tick(1);
        n++;
      end
      tick(50);
      chk("repeat_strobes", n_strobes - n0, 4);
      pm[2] = 4'b0000;
      wait_release();
    end
`endif
    tick(3);
    wait_row(4'b0100);
    glitch = 4'b0010;
    tick(6);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_r_sel", kif.r_sel, 4'b0001);
    chk("mid_rst_valid", kif.key_valid, 0);
    chk("mid_rst_held", kif.key_held, 0);
    chk("mid_rst_last", kif.last_key, 0);
    chk("mid_rst_prev", kif.prev_key, 0);
    chk("mid_rst_code", kif.key_code, 0);
    glitch = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick(30);
    chk("missing_strobes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
